// File: rtl/uart_tx_frame.sv
// UART transmitter: 5-9 data bits, none/odd/even parity, 1 or 2 stop bits, with a
// one-entry holding register for gapless back-to-back frames. UART_TX_BREAK_EN adds break generation.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 100,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
`ifdef UART_TX_BREAK_EN
  input  logic                 i_Tx_Break,
`endif
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
`ifdef UART_TX_BREAK_EN
  localparam logic [2:0] S_BRK   = 3'd5;
  localparam logic [2:0] S_MARK  = 3'd6;
`endif

  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 par_q, par_d;
  logic                 serial_q, serial_d;
  logic                 active_q, active_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;

  logic                 accept, bit_end, busy, brk_st, load_en;
  logic [DATA_BITS-1:0] load_val;

  always_comb begin
    state_d     = state_q;
    cnt_d       = bit_end ? '0 : cnt_q + 1'b1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    par_d       = par_q;
    done_d      = 1'b0;
    load_en     = 1'b0;
    load_val    = i_Tx_Byte;
    accept      = i_Tx_DV && ready_q;
    bit_end     = (cnt_q == CNT_MAX);
    busy        = (state_q == S_START) || (state_q == S_DATA) ||
                  (state_q == S_PAR)   || (state_q == S_STOP);

    // While a frame is on the line a new byte parks in the holding register.
    if (accept && busy) begin
      hold_d      = i_Tx_Byte;
      hold_full_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
`ifdef UART_TX_BREAK_EN
        if (i_Tx_Break) state_d = S_BRK;
        else
`endif
        if (accept) begin
          load_en = 1'b1;
          state_d = S_START;
        end
      end
      S_START: if (bit_end) begin
        state_d = S_DATA;
        bit_d   = '0;
      end
      S_DATA: if (bit_end) begin
        if (bit_q == LAST_DATA) begin
          state_d = (PARITY != 0) ? S_PAR : S_STOP;
          bit_d   = '0;
        end else begin
          bit_d   = bit_q + 4'd1;
          shift_d = shift_q >> 1;
        end
      end
      S_PAR: if (bit_end) begin
        state_d = S_STOP;
        bit_d   = '0;
      end
      S_STOP: if (bit_end) begin
        if (bit_q == LAST_STOP) begin
          done_d = 1'b1;
          bit_d  = '0;
          if (hold_full_q) begin
            load_en     = 1'b1;
            load_val    = hold_q;
            hold_full_d = 1'b0;
            state_d     = S_START;
          end else if (accept) begin
            // Byte offered on the final stop cycle goes straight to the shifter.
            load_en     = 1'b1;
            hold_full_d = 1'b0;
            state_d     = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BRK: begin
        cnt_d = '0;
        if (!i_Tx_Break) state_d = S_MARK;
      end
      S_MARK: if (bit_end) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase

    if (load_en) begin
      shift_d = load_val;
      par_d   = (PARITY == 2) ? ^load_val : ~^load_val;
    end

`ifdef UART_TX_BREAK_EN
    brk_st = (state_d == S_BRK) || (state_d == S_MARK);
`else
    brk_st = 1'b0;
`endif

    case (state_d)
      S_START: serial_d = 1'b0;
      S_DATA:  serial_d = shift_d[0];
      S_PAR:   serial_d = par_d;
`ifdef UART_TX_BREAK_EN
      S_BRK:   serial_d = 1'b0;
`endif
      default: serial_d = 1'b1;
    endcase

    active_d = (state_d != S_IDLE);
    ready_d  = !hold_full_d && !brk_st;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      par_q       <= 1'b0;
      serial_q    <= 1'b1;
      active_q    <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      par_q       <= par_d;
      serial_q    <= serial_d;
      active_q    <= active_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
    end
  end

  assign o_Tx_Serial = serial_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Ready  = ready_q;
  assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three frame formats checked cycle by cycle against a frame-level line model.
module tb_uart_tx_frame;
  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       dv_a, dv_b, dv_c;
  logic [7:0] byte_a, byte_b;
  logic [6:0] byte_c;
  logic       rdy_a, act_a, ser_a, done_a;
  logic       rdy_b, act_b, ser_b, done_b;
  logic       rdy_c, act_c, ser_c, done_c;
`ifdef UART_TX_BREAK_EN
  logic       brk_a, brk_off;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_a (
    .i_Clock(clk), .i_Reset(rst),
`ifdef UART_TX_BREAK_EN
    .i_Tx_Break(brk_a),
`endif
    .i_Tx_DV(dv_a), .i_Tx_Byte(byte_a), .o_Tx_Ready(rdy_a), .o_Tx_Active(act_a),
    .o_Tx_Serial(ser_a), .o_Tx_Done(done_a));

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_b (
    .i_Clock(clk), .i_Reset(rst),
`ifdef UART_TX_BREAK_EN
    .i_Tx_Break(brk_off),
`endif
    .i_Tx_DV(dv_b), .i_Tx_Byte(byte_b), .o_Tx_Ready(rdy_b), .o_Tx_Active(act_b),
    .o_Tx_Serial(ser_b), .o_Tx_Done(done_b));

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut_c (
    .i_Clock(clk), .i_Reset(rst),
`ifdef UART_TX_BREAK_EN
    .i_Tx_Break(brk_off),
`endif
    .i_Tx_DV(dv_c), .i_Tx_Byte(byte_c), .o_Tx_Ready(rdy_c), .o_Tx_Active(act_c),
    .o_Tx_Serial(ser_c), .o_Tx_Done(done_c));

  // Line level at cycle c of a frame, from the frame layout: start, data LSB first, parity, stops.
  function automatic logic ref_bit(input int data, input int nb, input int par, input int c);
    int b, ones;
    b = c / CPB;
    if (b == 0) return 1'b0;
    if (b <= nb) return 1'(data >> (b - 1));
    if (par != 0 && b == nb + 1) begin
      ones = $countones(data & ((1 << nb) - 1));
      return (par == 2) ? 1'(ones % 2) : 1'(1 - ones % 2);
    end
    return 1'b1;
  endfunction

  function automatic int flen(input int nb, input int par, input int ns);
    return (1 + nb + ((par != 0) ? 1 : 0) + ns) * CPB;
  endfunction

  task automatic chk(input string tag, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s @%0d: got %0h expected %0h", tag, idx, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // First byte accepted from IDLE at cycle 0; if k>0 a second byte is offered for edge k.
  task automatic frame_a(input logic [7:0] b1, input logic [7:0] b2, input int k);
    int len, last;
    bit two;
    two  = (k > 0);
    len  = flen(8, 2, 1);
    last = two ? 2 * len : len;
    dv_a = 1'b1; byte_a = b1;
    tick();
    for (int c = 0; c <= last; c++) begin
      if (c < len)             chk("a_serial", c, 32'(ser_a), 32'(ref_bit(b1, 8, 2, c)));
      else if (two && c < last) chk("a_serial", c, 32'(ser_a), 32'(ref_bit(b2, 8, 2, c - len)));
      else                      chk("a_serial", c, 32'(ser_a), 32'd1);
      chk("a_done", c, 32'(done_a), 32'((c == len) || (two && c == last)));
      chk("a_active", c, 32'(act_a), 32'(c < last));
      chk("a_ready", c, 32'(rdy_a), 32'(!(two && k < len && c >= k && c < len)));
      if (two && c + 1 == k) begin dv_a = 1'b1; byte_a = b2; end
      else begin dv_a = 1'b0; byte_a = 8'($urandom); end
      tick();
    end
  endtask

  initial begin
    int lb, lc;
    logic [7:0] rb;
    rst = 1'b1;
    dv_a = 0; dv_b = 0; dv_c = 0; byte_a = 0; byte_b = 0; byte_c = 0;
`ifdef UART_TX_BREAK_EN
    brk_a = 0; brk_off = 0;
`endif
    #12;
    chk("rst_serial", 0, 32'(ser_a), 32'd1);
    chk("rst_ready",  0, 32'(rdy_a), 32'd1);
    chk("rst_active", 0, 32'(act_a), 32'd0);
    chk("rst_done",   0, 32'(done_a), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    frame_a(8'h35, 8'h00, 0);
    frame_a(8'hA5, 8'h3C, 1);
    for (int i = 0; i < 6; i++) begin
      frame_a(8'($urandom), 8'($urandom), (i == 5) ? 44 : int'($urandom_range(0, 44)));
      repeat ($urandom_range(0, 3)) tick();
    end

    // odd parity on 0x00 and 0xFF
    lb = flen(8, 1, 1);
    for (int j = 0; j < 2; j++) begin
      rb = (j == 0) ? 8'h00 : 8'hFF;
      dv_b = 1'b1; byte_b = rb;
      tick();
      dv_b = 1'b0;
      for (int c = 0; c <= lb; c++) begin
        chk("b_serial", c, 32'(ser_b), (c < lb) ? 32'(ref_bit(rb, 8, 1, c)) : 32'd1);
        chk("b_done", c, 32'(done_b), 32'(c == lb));
        if (c == 9 * CPB + 2) chk("b_parity", c, 32'(ser_b), 32'd1);
        tick();
      end
    end

    // 7 data bits, no parity, 2 stop bits
    lc = flen(7, 0, 2);
    chk("c_len", 0, 32'(lc), 32'd40);
    dv_c = 1'b1; byte_c = 7'h7F;
    tick();
    dv_c = 1'b0;
    for (int c = 0; c <= lc; c++) begin
      chk("c_serial", c, 32'(ser_c), (c < lc) ? 32'(ref_bit(7'h7F, 7, 0, c)) : 32'd1);
      chk("c_done", c, 32'(done_c), 32'(c == lc));
      chk("c_active", c, 32'(act_c), 32'(c < lc));
      tick();
    end

    // reset during data bit 3 with a byte held
    rb = 8'($urandom);
    dv_a = 1'b1; byte_a = rb;
    tick();
    byte_a = 8'($urandom);
    tick();
    dv_a = 1'b0;
    chk("mid_ready_held", 1, 32'(rdy_a), 32'd0);
    repeat (16) tick();
    chk("mid_serial_pre", 17, 32'(ser_a), 32'(ref_bit(rb, 8, 2, 17)));
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_serial", 0, 32'(ser_a), 32'd1);
    chk("mid_rst_ready",  0, 32'(rdy_a), 32'd1);
    chk("mid_rst_active", 0, 32'(act_a), 32'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      chk("post_rst_serial", c, 32'(ser_a), 32'd1);
      chk("post_rst_done",   c, 32'(done_a), 32'd0);
      chk("post_rst_active", c, 32'(act_a), 32'd0);
    end

`ifdef UART_TX_BREAK_EN
    brk_a = 1'b1;
    tick();
    for (int c = 0; c < 20; c++) begin
      chk("brk_serial", c, 32'(ser_a), 32'd0);
      chk("brk_ready",  c, 32'(rdy_a), 32'd0);
      chk("brk_active", c, 32'(act_a), 32'd1);
      dv_a = (c >= 5 && c < 10);
      byte_a = 8'($urandom);
      if (c == 19) brk_a = 1'b0;
      tick();
    end
    for (int c = 20; c < 24; c++) begin
      chk("mark_serial", c, 32'(ser_a), 32'd1);
      chk("mark_ready",  c, 32'(rdy_a), 32'd0);
      tick();
    end
    chk("brk_end_ready", 24, 32'(rdy_a), 32'd1);
    for (int c = 0; c < 50; c++) begin
      chk("brk_no_frame", c, 32'(ser_a), 32'd1);
      chk("brk_no_done",  c, 32'(done_a), 32'd0);
      tick();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter with configurable frame format (5–9 data bits, none/odd/even parity, 1 or 2 stop bits) and a one-entry holding register, so back-to-back frames leave the line with zero idle gap. It sits between a byte producer (command/telemetry logic) and the serial TX pin. It supersedes the fixed 8N1 transmitter for all new serial links.

## Interface
Parameters:
- CLKS_PER_BIT, 100: clock cycles per bit; legal range ≥ 2.
- DATA_BITS, 8: data bits per frame; legal range 5–9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- i_Clock  in  1  clock
- i_Reset  in  1  reset; asynchronous, active-high
- i_Tx_DV  in  1  byte valid; accepted when i_Tx_DV && o_Tx_Ready
- i_Tx_Byte  in  DATA_BITS  payload, sent LSB first
- o_Tx_Ready  out  1  holding register empty
- o_Tx_Active  out  1  frame in progress on the line
- o_Tx_Serial  out  1  serial line, idle high
- o_Tx_Done  out  1  one-cycle pulse at the end of each frame

## Operation
- States: IDLE, START, DATA, PARITY, STOP. PARITY is skipped when PARITY = 0.
- Each state holds for CLKS_PER_BIT cycles. DATA repeats DATA_BITS times. STOP repeats STOP_BITS times.
- Frame length is (1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS) × CLKS_PER_BIT cycles.
- Accept in IDLE: the byte loads into the shifter, and the state moves to START.
- Accept while busy: the byte loads into the holding register, and o_Tx_Ready falls.
- End of frame (last cycle of the final stop bit):
  - If the holding register is full, the held byte moves to the shifter and START begins on the next cycle (no gap). o_Tx_Ready rises.
  - Otherwise, if i_Tx_DV is high on that cycle, the new byte loads directly into the shifter (back-to-back).
  - Otherwise, the state returns to IDLE.
- Parity is computed over the DATA_BITS payload, latched when the byte enters the shifter:
  - even: bit = XOR of the payload bits.
  - odd: bit = inverted XOR of the payload bits.
- Bit counter: 4 bits. Cycle counter: $clog2(CLKS_PER_BIT) bits; it wraps to 0 at CLKS_PER_BIT−1.
- i_Tx_Byte is sampled only at the accept edge. Later changes have no effect.

## Timing
- Reset values: o_Tx_Serial = 1, o_Tx_Ready = 1, o_Tx_Active = 0, o_Tx_Done = 0. State = IDLE, counters = 0, holding register empty.
- Reset mid-frame: the line returns high immediately (asynchronous). The current frame and any held byte are discarded.
- Accept edge N from IDLE: o_Tx_Serial = 0 and o_Tx_Active = 1 from edge N, so the start bit is exactly CLKS_PER_BIT cycles.
- o_Tx_Done is high for the one cycle following the final stop-bit cycle. It is asserted alongside the next start bit when frames are back-to-back.
- o_Tx_Active:
  - Stays high across back-to-back frames.
  - Falls on the same edge that o_Tx_Done rises, when no further frame follows.
- All outputs are registered. o_Tx_Ready has no combinational path from i_Tx_DV.

## Configuration
- UART_TX_BREAK_EN defined:
  - Adds input i_Tx_Break (1 bit).
  - i_Tx_Break is sampled only in IDLE with the holding register empty. While it is high there:
    - o_Tx_Serial = 0.
    - o_Tx_Active = 1.
    - o_Tx_Ready = 0.
  - Asserting i_Tx_Break mid-frame has no effect until the line reaches IDLE.
  - On release, the line goes high on the next edge and is held as mark for CLKS_PER_BIT cycles before o_Tx_Ready rises.
- Macro undefined:
  - The port is absent.
  - The line is low only during start bits, 0-valued data bits, and 0-valued parity bits.

## Test plan
- CLKS_PER_BIT = 4, DATA_BITS = 8, PARITY = 2, STOP_BITS = 1; send 0x35.
  - Line: 0, then 1,0,1,0,1,1,0,0, then parity 0, then 1; each bit 4 cycles, 44 cycles total.
  - o_Tx_Done pulses once, at cycle 44.
- Same configuration; send 0xA5 then 0x3C on consecutive cycles.
  - o_Tx_Ready is low from cycle 1 to cycle 44.
  - The second start bit begins exactly 44 cycles after the first.
  - o_Tx_Active never drops between the frames.
  - Two o_Tx_Done pulses, 44 cycles apart.
- PARITY = 1; send 0x00 → parity bit = 1. Send 0xFF → parity bit = 1.
- DATA_BITS = 7, PARITY = 0, STOP_BITS = 2; send 0x7F.
  - Frame: 1 start, seven 1s, 2 stop bits; 40 cycles at CLKS_PER_BIT = 4.
- Assert i_Reset during data bit 3 with a byte held.
  - o_Tx_Serial = 1 immediately; o_Tx_Ready = 1; o_Tx_Active = 0.
  - No o_Tx_Done pulse, and no further frame after release.
- UART_TX_BREAK_EN defined: hold i_Tx_Break for 20 cycles in IDLE.
  - Line low for 20 cycles, then high for 4 cycles before o_Tx_Ready = 1.
  - A byte offered during the break is not accepted.
